// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states, data-length codes
// and the latched frame format.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] BITLEN_5 = 2'b00;
  localparam logic [1:0] BITLEN_6 = 2'b01;
  localparam logic [1:0] BITLEN_7 = 2'b10;
  localparam logic [1:0] BITLEN_8 = 2'b11;

  localparam logic TXD_IDLE = 1'b1;

  // Frame format captured at each pop so mid-frame input changes cannot disturb it
  typedef struct packed {
    logic [1:0] bitlen;
    logic       parity_en;
    logic       odd_parity;
    logic       stop2;
  } uart_fmt_t;

  function automatic logic [DATA_W-1:0] data_mask(input logic [1:0] bitlen);
    logic [DATA_W-1:0] m;
    case (bitlen)
      BITLEN_5: m = 8'h1F;
      BITLEN_6: m = 8'h3F;
      BITLEN_7: m = 8'h7F;
      BITLEN_8: m = 8'hFF;
      default:  m = 8'hFF;
    endcase
    return m;
  endfunction

  // Index of the final data bit: bitlen code + 4
  function automatic logic [2:0] last_data_bit(input logic [1:0] bitlen);
    return 3'(bitlen) + 3'd4;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake between host and the UART transmit FIFO.
interface uart_tx_fifo_if #(
  parameter int unsigned LVL_W = 4
);
  logic             wr_valid_i;
  logic [7:0]       wr_data_i;
  logic             wr_ready_o;
  logic [LVL_W-1:0] level_o;

  modport master (output wr_valid_i, output wr_data_i, input wr_ready_o, input level_o);
  modport slave  (input wr_valid_i, input wr_data_i, output wr_ready_o, output level_o);
endinterface

// File: rtl/uart_tx_fifo_buf.sv
// Synchronous FIFO with registered count/full/empty; DEPTH must be a power of two.
module uart_tx_fifo_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       m_clock,
  input  logic                       p_reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_d;
  logic             push;
  logic             pop;

  // Writes while full are dropped; pops while empty are ignored
  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  always_comb begin
    count_d = count;
    if (push && !pop) begin
      count_d = count + CW'(1);
    end else if (pop && !push) begin
      count_d = count - CW'(1);
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge m_clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, runtime-configurable baud/length/parity/stop.
// Optional UART_TX_BREAK_EN adds break_i to hold txd_o low while idle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             m_clock,
  input  logic             p_reset,
`ifdef UART_TX_BREAK_EN
  input  logic             break_i,
`endif
  input  logic [DIV_W-1:0] div_i,
  input  logic [1:0]       bitlen_i,
  input  logic             parity_en_i,
  input  logic             odd_parity_i,
  input  logic             stop2_i,
  input  logic             enable_i,
  uart_tx_fifo_if.slave    wr_if,
  output logic             busy_o,
  output logic             done_o,
  output logic             txd_o
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  uart_state_e        state, state_d;
  logic [DIV_W-1:0]   baud_cnt, baud_d;
  logic [DIV_W-1:0]   div_l, div_d;
  logic [2:0]         bit_cnt, bit_d;
  logic [DATA_W-1:0]  shreg, shreg_d;
  uart_fmt_t          fmt_l, fmt_d;
  logic               par_l, par_d;
  logic               txd_d, busy_d, done_d;
  logic               pop, bit_end, launch_ok;
  logic               brk_hold, idle_lvl;
  logic [DATA_W-1:0]  fifo_rd, masked;
  logic [LVL_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;

  uart_tx_fifo_buf #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .wr_en   (wr_if.wr_valid_i),
    .wr_data (wr_if.wr_data_i),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign wr_if.wr_ready_o = ~fifo_full;
  assign wr_if.level_o    = LVL_W'(fifo_count);

`ifdef UART_TX_BREAK_EN
  logic brk_q;

  // Release is seen one cycle late so txd_o shows a mark cycle before any launch
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) brk_q <= 1'b0;
    else          brk_q <= break_i;
  end

  assign brk_hold = break_i | brk_q;
  assign idle_lvl = break_i ? 1'b0 : TXD_IDLE;
`else
  assign brk_hold = 1'b0;
  assign idle_lvl = TXD_IDLE;
`endif

  assign launch_ok = enable_i & ~fifo_empty & ~brk_hold;
  assign masked    = fifo_rd & data_mask(bitlen_i);

  // Next-state, datapath and registered-output lookahead
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_cnt;
    shreg_d = shreg;
    div_d   = div_l;
    fmt_d   = fmt_l;
    par_d   = par_l;
    pop     = 1'b0;
    bit_end = (baud_cnt == div_l);

    if (state == ST_IDLE) begin
      baud_d = '0;
    end else begin
      baud_d = bit_end ? '0 : baud_cnt + DIV_W'(1);
    end

    case (state)
      ST_IDLE: pop = launch_ok;
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg >> 1;
          if (bit_cnt == last_data_bit(fmt_l.bitlen)) begin
            state_d = fmt_l.parity_en ? ST_PARITY : ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt == 3'(fmt_l.stop2)) begin
            if (launch_ok) pop = 1'b1;
            else           state_d = ST_IDLE;
          end else begin
            bit_d = bit_cnt + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      state_d = ST_START;
      baud_d  = '0;
      bit_d   = '0;
      div_d   = div_i;
      fmt_d   = '{bitlen: bitlen_i, parity_en: parity_en_i,
                  odd_parity: odd_parity_i, stop2: stop2_i};
      shreg_d = masked;
      par_d   = ^masked;
    end

    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_d[0];
      ST_PARITY: txd_d = par_d ^ fmt_d.odd_parity;
      ST_STOP:   txd_d = TXD_IDLE;
      default:   txd_d = idle_lvl;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (baud_d == div_d) && (bit_d == 3'(fmt_d.stop2));
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      div_l    <= '0;
      fmt_l    <= '0;
      par_l    <= 1'b0;
      txd_o    <= TXD_IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shreg    <= shreg_d;
      div_l    <= div_d;
      fmt_l    <= fmt_d;
      par_l    <= par_d;
      txd_o    <= txd_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo; frame patterns are written in
// transmit order ('0'/'1' per bit period, start bit first).
module tb_uart_tx_fifo;

  logic        m_clock = 1'b0;
  logic        p_reset = 1'b0;
  logic [15:0] div_i;
  logic [1:0]  bitlen_i;
  logic        parity_en_i, odd_parity_i, stop2_i, enable_i;
  logic        busy_o, done_o, txd_o;
`ifdef UART_TX_BREAK_EN
  logic        break_i;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_if #(.LVL_W(4)) wr_if ();

  uart_tx_fifo #(.DIV_W(16), .FIFO_DEPTH(8)) dut (
    .m_clock      (m_clock),
    .p_reset      (p_reset),
`ifdef UART_TX_BREAK_EN
    .break_i      (break_i),
`endif
    .div_i        (div_i),
    .bitlen_i     (bitlen_i),
    .parity_en_i  (parity_en_i),
    .odd_parity_i (odd_parity_i),
    .stop2_i      (stop2_i),
    .enable_i     (enable_i),
    .wr_if        (wr_if),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .txd_o        (txd_o)
  );

  always #5 m_clock = ~m_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_if.wr_valid_i = 1'b1;
    wr_if.wr_data_i  = d;
    tick();
    wr_if.wr_valid_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_txd"},  32'(txd_o),  32'd1);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
  endtask

  // Called on the first start-bit cycle; ends on the cycle after the last stop cycle
  task automatic run_frame(input string tag, input string pat, input int per);
    for (int i = 0; i < pat.len(); i++) begin
      for (int c = 0; c < per; c++) begin
        check($sformatf("%s_txd_b%0d_c%0d", tag, i, c), 32'(txd_o), 32'(pat.getc(i) == "1"));
        check($sformatf("%s_done_b%0d_c%0d", tag, i, c), 32'(done_o),
              32'((i == pat.len() - 1) && (c == per - 1)));
        check($sformatf("%s_busy_b%0d", tag, i), 32'(busy_o), 32'd1);
        tick();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    div_i = 16'd3; bitlen_i = 2'b11; parity_en_i = 1'b0; odd_parity_i = 1'b0;
    stop2_i = 1'b0; enable_i = 1'b1;
    wr_if.wr_valid_i = 1'b0; wr_if.wr_data_i = 8'h00;
`ifdef UART_TX_BREAK_EN
    break_i = 1'b0;
`endif

    // Reset state
    repeat (2) tick();
    check_idle("rst");
    check("rst_ready", 32'(wr_if.wr_ready_o), 32'd1);
    check("rst_level", 32'(wr_if.level_o), 32'd0);
    p_reset = 1'b1;
    repeat (2) tick();

    // Basic 8-bit frame, div=3: start bit two cycles after the write
    push(8'h38);
    check("t2_lvl_w", 32'(wr_if.level_o), 32'd1);
    check("t2_txd_w", 32'(txd_o), 32'd1);
    tick();
    check("t2_lvl_s", 32'(wr_if.level_o), 32'd0);
    run_frame("t2", "0000111001", 4);
    check_idle("t2_end");

    // 5-bit, parity, two stop bits, div=1
    div_i = 16'd1; bitlen_i = 2'b00; parity_en_i = 1'b1; stop2_i = 1'b1;
    odd_parity_i = 1'b0;
    push(8'h07);
    tick();
    run_frame("t3e", "011100111", 2);
    check_idle("t3e_end");
    odd_parity_i = 1'b1;
    push(8'h07);
    tick();
    run_frame("t3o", "011100011", 2);
    check_idle("t3o_end");

    // Fill FIFO with launches held off; ninth write is dropped
    div_i = 16'd0; bitlen_i = 2'b11; parity_en_i = 1'b0; stop2_i = 1'b0;
    odd_parity_i = 1'b0; enable_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_if.wr_valid_i = 1'b1;
      wr_if.wr_data_i  = (i == 8) ? 8'hFF : ((i % 2) != 0 ? 8'h0F : 8'h55);
      tick();
      check($sformatf("t4_lvl%0d", i), 32'(wr_if.level_o), 32'((i < 8) ? i + 1 : 8));
      check($sformatf("t4_rdy%0d", i), 32'(wr_if.wr_ready_o), 32'((i + 1) < 8));
    end
    wr_if.wr_valid_i = 1'b0;
    check_idle("t4_hold");
    enable_i = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_lvl_f%0d", k), 32'(wr_if.level_o), 32'(7 - k));
      run_frame($sformatf("t4f%0d", k), (k % 2) != 0 ? "0111100001" : "0101010101", 1);
    end
    check_idle("t4_end");
    check("t4_lvl_end", 32'(wr_if.level_o), 32'd0);
    repeat (3) tick();
    check_idle("t4_quiet");

    // 1-cycle bits, simultaneous push/pop, mid-frame input changes
    bitlen_i = 2'b10;
    push(8'h5A);
    check("t5_lvl_w", 32'(wr_if.level_o), 32'd1);
    push(8'h33);
    check("t5_lvl_pp", 32'(wr_if.level_o), 32'd1);
    div_i = 16'd5; bitlen_i = 2'b11; parity_en_i = 1'b1; stop2_i = 1'b1; enable_i = 1'b0;
    run_frame("t5", "001011011", 1);
    repeat (4) tick();
    check_idle("t5_hold");
    check("t5_lvl_hold", 32'(wr_if.level_o), 32'd1);

    // Reset in the middle of a frame with data still queued
    div_i = 16'd3; parity_en_i = 1'b0; stop2_i = 1'b0; enable_i = 1'b1;
    repeat (7) tick();
    push(8'hAA);
    check("t1_busy_pre", 32'(busy_o), 32'd1);
    check("t1_lvl_pre", 32'(wr_if.level_o), 32'd1);
    #2 p_reset = 1'b0;
    #1;
    check_idle("t1_async");
    check("t1_ready", 32'(wr_if.wr_ready_o), 32'd1);
    check("t1_level", 32'(wr_if.level_o), 32'd0);
    tick();
    p_reset = 1'b1;
    repeat (20) tick();
    check_idle("t1_after");
    check("t1_lvl_after", 32'(wr_if.level_o), 32'd0);

`ifdef UART_TX_BREAK_EN
    // Break holds the line low in IDLE and blocks the pop until released
    break_i = 1'b1;
    push(8'h01);
    check("t6_txd_brk", 32'(txd_o), 32'd0);
    repeat (3) tick();
    check("t6_txd_hold", 32'(txd_o), 32'd0);
    check("t6_lvl_hold", 32'(wr_if.level_o), 32'd1);
    check("t6_busy_hold", 32'(busy_o), 32'd0);
    break_i = 1'b0;
    tick();
    check("t6_txd_rel", 32'(txd_o), 32'd1);
    check("t6_lvl_rel", 32'(wr_if.level_o), 32'd1);
    tick();
    check("t6_lvl_pop", 32'(wr_if.level_o), 32'd0);
    run_frame("t6", "0100000001", 4);
    check_idle("t6_end");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the fixed-pattern UART transmit path.
- Buffered asynchronous-serial transmitter: bytes are pushed into an internal FIFO and sent back-to-back on txd_o.
- Baud divider, data length (5-8 bits), parity and stop-bit count are set at runtime.
- Sits between a host/sequencer and the board TXD pin, replacing the hard-wired data/start-pulse arrangement.

Parameters:
- DIV_W, 16, width of the baud divider input and its counter.
- FIFO_DEPTH, 8, number of FIFO entries. Must be a power of two, at least 2.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of level_o. Derived; do not override.

Ports:
- m_clock  in  1  system clock, rising edge.
- p_reset  in  1  asynchronous reset, active-low.
- div_i  in  DIV_W  bit period minus 1, in m_clock cycles.
- bitlen_i  in  2  data length: 00=5, 01=6, 10=7, 11=8 bits.
- parity_en_i  in  1  1 = append a parity bit.
- odd_parity_i  in  1  1 = odd parity, 0 = even parity.
- stop2_i  in  1  1 = two stop bits, 0 = one stop bit.
- enable_i  in  1  permits new frames to launch.
- wr_valid_i  in  1  write request.
- wr_data_i  in  8  write data. Only bits [bitlen+4:0] are transmitted.
- wr_ready_o  out  1  FIFO not full.
- level_o  out  LVL_W  current FIFO occupancy.
- busy_o  out  1  a frame is in progress (state != IDLE).
- done_o  out  1  one-cycle pulse at the last cycle of the final stop bit.
- txd_o  out  1  serial output, idles high.

Behaviour:
Reset values:
- txd_o=1, wr_ready_o=1, level_o=0, busy_o=0, done_o=0.
- FIFO empty, state IDLE, baud counter 0.
- Reset mid-frame aborts the frame: txd_o goes to 1 asynchronously and FIFO contents are discarded.

FIFO:
- Write accepted when wr_valid_i & wr_ready_o. Writes while full are dropped silently; there is no bypass.
- Simultaneous accepted write and pop: level_o unchanged.
- wr_ready_o and level_o are registered.

Frame launch:
- In IDLE with enable_i=1 and level_o>0, pop the head.
- Latch div_i, bitlen_i, parity_en_i, odd_parity_i and stop2_i at the pop.
- Go to START next cycle; txd_o=0 from that cycle.
- Latency from an accepted write into an empty FIFO in IDLE to the first start-bit cycle: 2 cycles.

Timing:
- Each bit lasts exactly latched div+1 cycles. div=0 gives 1-cycle bits.
- Input changes mid-frame have no effect on the current frame.

State machine:
- IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
- DATA: LSB first, bitlen+5 bits.
- PARITY: present only if parity_en. Value = XOR of the transmitted bits; inverted when odd parity.
- STOP: txd_o=1 for 1 or 2 bit periods.
- On the last STOP cycle: done_o=1. If enable_i=1 and the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.

enable_i:
- Deasserting mid-frame lets the current frame complete; no further launches follow.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input break_i (1 bit). While break_i=1 and state is IDLE, txd_o=0 and no pops occur. Release returns txd_o to 1 the next cycle; a launch may then occur in the same cycle the state machine sees break_i=0. break_i asserted mid-frame is ignored until IDLE.
- Not defined: the port is absent and the idle level is always 1.

Decomposition:
- Shared package uart_pkg:
  - state encoding (IDLE, START, DATA, PARITY, STOP)
  - bitlen encoding constants
  - TXD_IDLE=1'b1
- Sub-module uart_tx_fifo_buf: synchronous FIFO with parameters WIDTH and DEPTH, count output, full/empty flags, asynchronous active-low reset.
- The top level holds the baud counter, bit counter, shift register and state machine.

Test Plan:
1. Reset mid-frame:
   - Stimulus: assert p_reset low while a frame is in progress.
   - Response: txd_o=1, wr_ready_o=1, level_o=0, busy_o=0 and done_o=0 without a clock edge. No activity with an empty FIFO after release.
2. Basic 8-bit frame:
   - Stimulus: div=3, bitlen=11, no parity, 1 stop, write 0x38.
   - Response: txd_o = 0,0,0,0,1,1,1,0,0,1, each held 4 cycles. Start bit 2 cycles after the write. done_o single pulse at cycle 40 of the frame.
3. Parity, 5-bit, 2 stop:
   - Stimulus: div=1, bitlen=00, parity_en=1, stop2=1, write 0x07.
   - Response: data bits 1,1,1,0,0. Parity bit 1 when even, 0 when odd. Frame is 9 bits = 18 cycles.
4. Full FIFO and back-to-back:
   - Stimulus: enable_i=0, write 9 bytes.
   - Response: wr_ready_o=0 after 8 writes, 9th byte dropped, level_o=8.
   - Then raise enable_i: 8 contiguous frames with no idle cycle between the stop bit and the next start bit. level_o decrements at each pop. busy_o stays high throughout.
5. div=0 and mid-frame changes:
   - Stimulus: div=0; change div_i and bitlen_i during the frame; drop enable_i mid-frame.
   - Response: 1-cycle bits. The current frame keeps its latched settings and completes. No next launch while enable_i=0.
6. UART_TX_BREAK_EN (when defined):
   - Stimulus: break_i=1 with the FIFO non-empty and state IDLE.
   - Response: txd_o=0 and no pop. After release, txd_o=1 the next cycle and the frame launches.
